// File: rtl/ascon_aead_fsm.sv
// ASCON AEAD control FSM: sequences initialisation, AD, data and finalisation
// permutation rounds for encrypt or decrypt, and drives every datapath select and FIFO strobe.
module ascon_aead_fsm #(
    parameter int unsigned BLOCK_AW    = 7,
    parameter int unsigned DELAY_WIDTH = 16,
    parameter int unsigned ROUND_WIDTH = 4,
    parameter int unsigned PA_ROUNDS   = 12,
    parameter int unsigned PB_ROUNDS   = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic                   decrypt_i,
    input  logic                   abort_i,
    input  logic [BLOCK_AW-1:0]    ad_blk_no_i,
    input  logic [BLOCK_AW:0]      dt_blk_no_i,
    input  logic [DELAY_WIDTH-1:0] delay_i,
    input  logic                   ad_empty_i,
    input  logic                   din_empty_i,
    input  logic                   dout_full_i,
    input  logic                   tag_eq_i,
    output logic                   ready_o,
    output logic                   flush_o,
    output logic                   ad_pop_o,
    output logic                   din_pop_o,
    output logic                   dout_push_o,
    output logic                   en_state_o,
    output logic [ROUND_WIDTH-1:0] rnd_idx_o,
    output logic                   sel_state_init_o,
    output logic                   sel_xor_init_o,
    output logic                   sel_ad_o,
    output logic                   sel_xor_ext_o,
    output logic                   sel_ct_replace_o,
    output logic                   sel_xor_dom_sep_o,
    output logic                   sel_xor_fin_o,
    output logic                   sel_xor_tag_o,
    output logic                   done_o,
    output logic                   tag_valid_o,
    output logic                   auth_ok_o,
    output logic                   auth_fail_o
);

    localparam logic [ROUND_WIDTH-1:0] PA_LAST = ROUND_WIDTH'(PA_ROUNDS - 1);
    localparam logic [ROUND_WIDTH-1:0] PB_LAST = ROUND_WIDTH'(PB_ROUNDS - 1);
    localparam logic [ROUND_WIDTH-1:0] PA_BASE = ROUND_WIDTH'(12 - PA_ROUNDS);
    localparam logic [ROUND_WIDTH-1:0] PB_BASE = ROUND_WIDTH'(12 - PB_ROUNDS);

    typedef enum logic [3:0] {
        S_IDLE,
        S_DELAY,
        S_INIT,
        S_AD_WAIT,
        S_AD_ROUND,
        S_DT_WAIT,
        S_DT_ROUND,
        S_FIN_WAIT,
        S_FIN_ROUND,
        S_VERIFY,
        S_DONE
    } state_t;

    typedef struct packed {
        logic                   ready;
        logic                   flush;
        logic                   ad_pop;
        logic                   din_pop;
        logic                   dout_push;
        logic                   en_state;
        logic [ROUND_WIDTH-1:0] rnd_idx;
        logic                   sel_state_init;
        logic                   sel_xor_init;
        logic                   sel_ad;
        logic                   sel_xor_ext;
        logic                   sel_ct_replace;
        logic                   sel_xor_dom_sep;
        logic                   sel_xor_fin;
        logic                   sel_xor_tag;
        logic                   done;
        logic                   tag_valid;
        logic                   auth_ok;
        logic                   auth_fail;
    } ctrl_t;

    state_t                 state_q, state_n;
    logic [ROUND_WIDTH-1:0] k_q, k_n;
    logic [DELAY_WIDTH-1:0] timer_q, timer_n;
    logic [BLOCK_AW-1:0]    ad_cnt_q, ad_cnt_n;
    logic [BLOCK_AW-1:0]    ad_blk_q, ad_blk_n;
    logic [BLOCK_AW:0]      dt_rem_q, dt_rem_n;
    logic                   mode_q, mode_n;
    logic [1:0]             auth_q, auth_n;
    ctrl_t                  ctrl_q, ctrl_n;
    state_t                 post_ad;
    logic                   kill;

    // After the AD phase: non-final data blocks first, otherwise straight to the final block.
    assign post_ad = (dt_rem_q != '0) ? S_DT_WAIT : S_FIN_WAIT;
    assign kill    = abort_i && (state_q != S_IDLE);

    always_comb begin
        state_n  = state_q;
        k_n      = k_q;
        timer_n  = timer_q;
        ad_cnt_n = ad_cnt_q;
        ad_blk_n = ad_blk_q;
        dt_rem_n = dt_rem_q;
        mode_n   = mode_q;
        auth_n   = auth_q;
        if (kill) begin
            state_n = S_IDLE;
            auth_n  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        mode_n   = decrypt_i;
                        ad_blk_n = ad_blk_no_i;
                        ad_cnt_n = '0;
                        dt_rem_n = (dt_blk_no_i == '0) ? '0 : dt_blk_no_i - 1'b1;
                        timer_n  = '0;
                        auth_n   = '0;
                        state_n  = S_DELAY;
                    end
                end
                S_DELAY: begin
                    if (timer_q == delay_i) begin
                        k_n     = '0;
                        state_n = S_INIT;
                    end else begin
                        timer_n = timer_q + 1'b1;
                    end
                end
                S_INIT: begin
                    if (k_q == PA_LAST) begin
                        k_n     = '0;
                        state_n = (ad_blk_q != '0) ? S_AD_WAIT : post_ad;
                    end else begin
                        k_n = k_q + 1'b1;
                    end
                end
                S_AD_WAIT: begin
                    if (!ad_empty_i) begin
                        k_n     = '0;
                        state_n = S_AD_ROUND;
                    end
                end
                S_AD_ROUND: begin
                    if (k_q == '0) ad_cnt_n = ad_cnt_q + 1'b1;
                    if (k_q == PB_LAST) begin
                        k_n     = '0;
                        state_n = (ad_cnt_q == ad_blk_q) ? post_ad : S_AD_WAIT;
                    end else begin
                        k_n = k_q + 1'b1;
                    end
                end
                S_DT_WAIT, S_FIN_WAIT: begin
                    if (!din_empty_i && !dout_full_i) begin
                        k_n     = '0;
                        state_n = (state_q == S_DT_WAIT) ? S_DT_ROUND : S_FIN_ROUND;
                    end
                end
                S_DT_ROUND: begin
                    if (k_q == '0) dt_rem_n = dt_rem_q - 1'b1;
                    if (k_q == PB_LAST) begin
                        k_n     = '0;
                        state_n = (dt_rem_q == '0) ? S_FIN_WAIT : S_DT_WAIT;
                    end else begin
                        k_n = k_q + 1'b1;
                    end
                end
                S_FIN_ROUND: begin
                    if (k_q == PA_LAST) begin
                        k_n     = '0;
                        state_n = S_VERIFY;
                    end else begin
                        k_n = k_q + 1'b1;
                    end
                end
                S_VERIFY: begin
                    if (mode_q) auth_n = {tag_eq_i, !tag_eq_i};
                    state_n = S_DONE;
                end
                S_DONE: begin
                    if (!start_i) state_n = S_IDLE;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next-state values so the registered copy lines up with the state it describes.
    always_comb begin
        ctrl_n = '0;
        case (state_n)
            S_IDLE: begin
                ctrl_n.ready = 1'b1;
                ctrl_n.flush = 1'b1;
            end
            S_INIT: begin
                ctrl_n.en_state       = 1'b1;
                ctrl_n.rnd_idx        = PA_BASE + k_n;
                ctrl_n.sel_state_init = (k_n == '0);
                if (k_n == PA_LAST) begin
                    ctrl_n.sel_xor_init    = 1'b1;
                    ctrl_n.sel_xor_dom_sep = (ad_blk_n == '0);
                end
            end
            S_AD_ROUND: begin
                ctrl_n.en_state = 1'b1;
                ctrl_n.rnd_idx  = PB_BASE + k_n;
                if (k_n == '0) begin
                    ctrl_n.ad_pop      = 1'b1;
                    ctrl_n.sel_ad      = 1'b1;
                    ctrl_n.sel_xor_ext = 1'b1;
                end
                ctrl_n.sel_xor_dom_sep = (k_n == PB_LAST) && (ad_cnt_n == ad_blk_n);
            end
            S_DT_ROUND: begin
                ctrl_n.en_state = 1'b1;
                ctrl_n.rnd_idx  = PB_BASE + k_n;
                if (k_n == '0) begin
                    ctrl_n.din_pop        = 1'b1;
                    ctrl_n.dout_push      = 1'b1;
                    ctrl_n.sel_xor_ext    = 1'b1;
                    ctrl_n.sel_ct_replace = mode_n;
                end
            end
            S_FIN_ROUND: begin
                ctrl_n.en_state = 1'b1;
                ctrl_n.rnd_idx  = PA_BASE + k_n;
                if (k_n == '0) begin
                    ctrl_n.din_pop        = 1'b1;
                    ctrl_n.dout_push      = 1'b1;
                    ctrl_n.sel_xor_ext    = 1'b1;
                    ctrl_n.sel_xor_fin    = 1'b1;
                    ctrl_n.sel_ct_replace = mode_n;
                end
                ctrl_n.sel_xor_tag = (k_n == PA_LAST);
            end
            S_DONE: begin
                ctrl_n.done      = 1'b1;
                ctrl_n.tag_valid = ~mode_n;
                ctrl_n.auth_ok   = auth_n[1];
                ctrl_n.auth_fail = auth_n[0];
            end
            default: ctrl_n = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            k_q          <= '0;
            timer_q      <= '0;
            ad_cnt_q     <= '0;
            ad_blk_q     <= '0;
            dt_rem_q     <= '0;
            mode_q       <= 1'b0;
            auth_q       <= '0;
            ctrl_q       <= '0;
            ctrl_q.ready <= 1'b1;
            ctrl_q.flush <= 1'b1;
        end else begin
            state_q  <= state_n;
            k_q      <= k_n;
            timer_q  <= timer_n;
            ad_cnt_q <= ad_cnt_n;
            ad_blk_q <= ad_blk_n;
            dt_rem_q <= dt_rem_n;
            mode_q   <= mode_n;
            auth_q   <= auth_n;
            ctrl_q   <= ctrl_n;
        end
    end

    // Abort must silence the datapath in the very cycle it is seen, ahead of the registered outputs.
    assign ready_o           = ctrl_q.ready;
    assign flush_o           = ctrl_q.flush;
    assign ad_pop_o          = ctrl_q.ad_pop & ~kill;
    assign din_pop_o         = ctrl_q.din_pop & ~kill;
    assign dout_push_o       = ctrl_q.dout_push & ~kill;
    assign en_state_o        = ctrl_q.en_state & ~kill;
    assign rnd_idx_o         = ctrl_q.rnd_idx;
    assign sel_state_init_o  = ctrl_q.sel_state_init & ~kill;
    assign sel_xor_init_o    = ctrl_q.sel_xor_init & ~kill;
    assign sel_ad_o          = ctrl_q.sel_ad & ~kill;
    assign sel_xor_ext_o     = ctrl_q.sel_xor_ext & ~kill;
    assign sel_ct_replace_o  = ctrl_q.sel_ct_replace & ~kill;
    assign sel_xor_dom_sep_o = ctrl_q.sel_xor_dom_sep & ~kill;
    assign sel_xor_fin_o     = ctrl_q.sel_xor_fin & ~kill;
    assign sel_xor_tag_o     = ctrl_q.sel_xor_tag & ~kill;
    assign done_o            = ctrl_q.done;
    assign tag_valid_o       = ctrl_q.tag_valid;
    assign auth_ok_o         = ctrl_q.auth_ok;
    assign auth_fail_o       = ctrl_q.auth_fail;

endmodule

// File: tb/tb_ascon_aead_fsm.sv
// Directed bench for ascon_aead_fsm: cycle-exact timelines for encrypt, decrypt,
// no-AD, stall, abort and a PB_ROUNDS=8 build.
module tb_ascon_aead_fsm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i, start8, decrypt_i, abort_i;
    logic [6:0]  ad_blk_no_i;
    logic [7:0]  dt_blk_no_i;
    logic [15:0] delay_i;
    logic        ad_empty_i, din_empty_i, dout_full_i, tag_eq_i;

    logic        ready_o, flush_o, ad_pop_o, din_pop_o, dout_push_o, en_state_o;
    logic [3:0]  rnd_idx_o;
    logic        sel_state_init_o, sel_xor_init_o, sel_ad_o, sel_xor_ext_o, sel_ct_replace_o;
    logic        sel_xor_dom_sep_o, sel_xor_fin_o, sel_xor_tag_o;
    logic        done_o, tag_valid_o, auth_ok_o, auth_fail_o;

    logic        ready8, flush8, ad_pop8, din_pop8, dout_push8, en_state8;
    logic [3:0]  rnd_idx8;
    logic        sel_state_init8, sel_xor_init8, sel_ad8, sel_xor_ext8, sel_ct_replace8;
    logic        sel_xor_dom_sep8, sel_xor_fin8, sel_xor_tag8;
    logic        done8, tag_valid8, auth_ok8, auth_fail8;

    int vec = 0;
    int errs = 0;

    always #5 clk = ~clk;

    ascon_aead_fsm dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .decrypt_i(decrypt_i), .abort_i(abort_i),
        .ad_blk_no_i(ad_blk_no_i), .dt_blk_no_i(dt_blk_no_i), .delay_i(delay_i),
        .ad_empty_i(ad_empty_i), .din_empty_i(din_empty_i), .dout_full_i(dout_full_i), .tag_eq_i(tag_eq_i),
        .ready_o(ready_o), .flush_o(flush_o), .ad_pop_o(ad_pop_o), .din_pop_o(din_pop_o),
        .dout_push_o(dout_push_o), .en_state_o(en_state_o), .rnd_idx_o(rnd_idx_o),
        .sel_state_init_o(sel_state_init_o), .sel_xor_init_o(sel_xor_init_o), .sel_ad_o(sel_ad_o),
        .sel_xor_ext_o(sel_xor_ext_o), .sel_ct_replace_o(sel_ct_replace_o),
        .sel_xor_dom_sep_o(sel_xor_dom_sep_o), .sel_xor_fin_o(sel_xor_fin_o), .sel_xor_tag_o(sel_xor_tag_o),
        .done_o(done_o), .tag_valid_o(tag_valid_o), .auth_ok_o(auth_ok_o), .auth_fail_o(auth_fail_o)
    );

    ascon_aead_fsm #(.PB_ROUNDS(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start_i(start8), .decrypt_i(decrypt_i), .abort_i(abort_i),
        .ad_blk_no_i(ad_blk_no_i), .dt_blk_no_i(dt_blk_no_i), .delay_i(delay_i),
        .ad_empty_i(ad_empty_i), .din_empty_i(din_empty_i), .dout_full_i(dout_full_i), .tag_eq_i(tag_eq_i),
        .ready_o(ready8), .flush_o(flush8), .ad_pop_o(ad_pop8), .din_pop_o(din_pop8),
        .dout_push_o(dout_push8), .en_state_o(en_state8), .rnd_idx_o(rnd_idx8),
        .sel_state_init_o(sel_state_init8), .sel_xor_init_o(sel_xor_init8), .sel_ad_o(sel_ad8),
        .sel_xor_ext_o(sel_xor_ext8), .sel_ct_replace_o(sel_ct_replace8),
        .sel_xor_dom_sep_o(sel_xor_dom_sep8), .sel_xor_fin_o(sel_xor_fin8), .sel_xor_tag_o(sel_xor_tag8),
        .done_o(done8), .tag_valid_o(tag_valid8), .auth_ok_o(auth_ok8), .auth_fail_o(auth_fail8)
    );

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start_i = 1'b0; start8 = 1'b0; decrypt_i = 1'b0; abort_i = 1'b0;
        ad_blk_no_i = '0; dt_blk_no_i = '0; delay_i = '0;
        ad_empty_i = 1'b0; din_empty_i = 1'b0; dout_full_i = 1'b0; tag_eq_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vec++;
        if ({ready_o, flush_o, en_state_o, ad_pop_o, din_pop_o, dout_push_o, done_o, auth_ok_o, auth_fail_o} !== 9'b110000000) begin
            errs++; $display("FAIL reset_ctrl got %b want 110000000",
                {ready_o, flush_o, en_state_o, ad_pop_o, din_pop_o, dout_push_o, done_o, auth_ok_o, auth_fail_o});
        end
        vec++;
        if (rnd_idx_o !== 4'd0) begin errs++; $display("FAIL reset_rnd_idx got %0d want 0", rnd_idx_o); end
        vec++;
        if ({ready8, flush8, en_state8} !== 3'b110) begin errs++; $display("FAIL reset_pb8 got %b want 110", {ready8, flush8, en_state8}); end
        rst_n = 1'b1;
        @(negedge clk);
        vec++;
        if ({ready_o, tag_valid_o} !== 2'b10) begin errs++; $display("FAIL post_reset_idle got %b want 10", {ready_o, tag_valid_o}); end
    endtask

    task automatic test_encrypt;
        int n_ad, n_din, n_dout, n_done, first_done;
        logic exp_en;
        n_ad = 0; n_din = 0; n_dout = 0; n_done = 0; first_done = -1;
        next_cycle;
        decrypt_i = 1'b0; ad_blk_no_i = 7'd1; dt_blk_no_i = 8'd2; delay_i = 16'd0; tag_eq_i = 1'b0; start_i = 1'b1;
        @(negedge clk);
        vec++;
        if (ready_o !== 1'b1) begin errs++; $display("FAIL enc_ready_c0 got %b want 1", ready_o); end
        for (int c = 1; c <= 44; c++) begin
            next_cycle;
            start_i = 1'b0;
            @(negedge clk);
            exp_en = (c >= 2 && c <= 13) || (c >= 15 && c <= 20) || (c >= 22 && c <= 27) || (c >= 29 && c <= 40);
            vec++;
            if (en_state_o !== exp_en) begin errs++; $display("FAIL enc_en_state c%0d got %b want %b", c, en_state_o, exp_en); end
            if (ad_pop_o) n_ad++;
            if (din_pop_o) n_din++;
            if (dout_push_o) n_dout++;
            if (done_o === 1'b1) begin n_done++; if (first_done < 0) first_done = c; end
            case (c)
                2: begin vec++; if ({sel_state_init_o, rnd_idx_o} !== {1'b1, 4'd0}) begin errs++; $display("FAIL enc_init_k0 got %h want 10", {sel_state_init_o, rnd_idx_o}); end end
                13: begin vec++; if ({rnd_idx_o, sel_xor_init_o, sel_xor_dom_sep_o} !== {4'd11, 1'b1, 1'b0}) begin errs++; $display("FAIL enc_init_last got %b want 101110", {rnd_idx_o, sel_xor_init_o, sel_xor_dom_sep_o}); end end
                15: begin vec++; if ({rnd_idx_o, sel_ad_o, sel_xor_ext_o} !== {4'd6, 1'b1, 1'b1}) begin errs++; $display("FAIL enc_ad_k0 got %b want 011011", {rnd_idx_o, sel_ad_o, sel_xor_ext_o}); end end
                20: begin vec++; if ({rnd_idx_o, sel_xor_dom_sep_o} !== {4'd11, 1'b1}) begin errs++; $display("FAIL enc_ad_last got %b want 10111", {rnd_idx_o, sel_xor_dom_sep_o}); end end
                22: begin vec++; if ({din_pop_o, dout_push_o, sel_ct_replace_o, rnd_idx_o} !== {3'b110, 4'd6}) begin errs++; $display("FAIL enc_dt_k0 got %b want 1100110", {din_pop_o, dout_push_o, sel_ct_replace_o, rnd_idx_o}); end end
                29: begin vec++; if ({sel_xor_fin_o, din_pop_o, rnd_idx_o} !== {2'b11, 4'd0}) begin errs++; $display("FAIL enc_fin_k0 got %b want 110000", {sel_xor_fin_o, din_pop_o, rnd_idx_o}); end end
                40: begin vec++; if ({sel_xor_tag_o, rnd_idx_o} !== {1'b1, 4'd11}) begin errs++; $display("FAIL enc_fin_last got %b want 11011", {sel_xor_tag_o, rnd_idx_o}); end end
                42: begin vec++; if ({done_o, tag_valid_o, auth_ok_o, auth_fail_o} !== 4'b1100) begin errs++; $display("FAIL enc_done got %b want 1100", {done_o, tag_valid_o, auth_ok_o, auth_fail_o}); end end
                43: begin vec++; if (ready_o !== 1'b1) begin errs++; $display("FAIL enc_back_idle got %b want 1", ready_o); end end
                default: ;
            endcase
        end
        vec++;
        if (n_ad != 1 || n_din != 2 || n_dout != 2) begin errs++; $display("FAIL enc_strobe_counts got ad=%0d din=%0d dout=%0d want 1 2 2", n_ad, n_din, n_dout); end
        vec++;
        if (first_done != 42 || n_done != 1) begin errs++; $display("FAIL enc_done_cycle got c%0d x%0d want c42 x1", first_done, n_done); end
    endtask

    task automatic test_no_ad;
        int n_en, n_ad, n_din, first_done;
        for (int r = 0; r < 2; r++) begin
            n_en = 0; n_ad = 0; n_din = 0; first_done = -1;
            next_cycle;
            decrypt_i = 1'b0; ad_blk_no_i = 7'd0; dt_blk_no_i = (r == 0) ? 8'd1 : 8'd0; delay_i = 16'd0; start_i = 1'b1;
            for (int c = 1; c <= 29; c++) begin
                next_cycle;
                start_i = 1'b0;
                @(negedge clk);
                if (en_state_o) n_en++;
                if (ad_pop_o || sel_ad_o) n_ad++;
                if (din_pop_o) n_din++;
                if (done_o === 1'b1 && first_done < 0) first_done = c;
                if (c == 13) begin
                    vec++;
                    if ({rnd_idx_o, sel_xor_init_o, sel_xor_dom_sep_o} !== {4'd11, 2'b11}) begin
                        errs++; $display("FAIL noad_init_last r%0d got %b want 101111", r, {rnd_idx_o, sel_xor_init_o, sel_xor_dom_sep_o});
                    end
                end
            end
            vec++;
            if (n_en != 24 || n_ad != 0 || n_din != 1) begin errs++; $display("FAIL noad_counts r%0d got en=%0d ad=%0d din=%0d want 24 0 1", r, n_en, n_ad, n_din); end
            vec++;
            if (first_done != 28) begin errs++; $display("FAIL noad_done_cycle r%0d got %0d want 28", r, first_done); end
        end
    endtask

    task automatic test_decrypt;
        int n_pop, n_rep;
        for (int r = 0; r < 2; r++) begin
            n_pop = 0; n_rep = 0;
            next_cycle;
            decrypt_i = 1'b1; ad_blk_no_i = 7'd0; dt_blk_no_i = 8'd2; delay_i = 16'd0;
            tag_eq_i = (r == 1); start_i = 1'b1;
            for (int c = 1; c <= 39; c++) begin
                next_cycle;
                start_i = (r == 1) && (c <= 37);
                @(negedge clk);
                if (din_pop_o) n_pop++;
                if (din_pop_o && sel_ct_replace_o) n_rep++;
                if (c == 35) begin
                    vec++;
                    if ({done_o, auth_ok_o, auth_fail_o, tag_valid_o} !== ((r == 1) ? 4'b1100 : 4'b1010)) begin
                        errs++; $display("FAIL dec_verdict r%0d got %b want %b", r, {done_o, auth_ok_o, auth_fail_o, tag_valid_o}, (r == 1) ? 4'b1100 : 4'b1010);
                    end
                end
                if (r == 1 && c == 38) begin
                    vec++;
                    if ({done_o, auth_ok_o} !== 2'b11) begin errs++; $display("FAIL dec_done_hold got %b want 11", {done_o, auth_ok_o}); end
                end
                if (r == 1 && c == 39) begin
                    vec++;
                    if ({ready_o, done_o, auth_ok_o} !== 3'b100) begin errs++; $display("FAIL dec_release got %b want 100", {ready_o, done_o, auth_ok_o}); end
                end
            end
            vec++;
            if (n_pop != 2 || n_rep != 2) begin errs++; $display("FAIL dec_ct_replace r%0d got pops=%0d replaced=%0d want 2 2", r, n_pop, n_rep); end
        end
        decrypt_i = 1'b0; tag_eq_i = 1'b0;
    endtask

    task automatic test_pb8;
        int first_done;
        first_done = -1;
        next_cycle;
        decrypt_i = 1'b0; ad_blk_no_i = 7'd1; dt_blk_no_i = 8'd2; delay_i = 16'd3; start8 = 1'b1;
        for (int c = 1; c <= 50; c++) begin
            next_cycle;
            start8 = 1'b0;
            @(negedge clk);
            if (done8 === 1'b1 && first_done < 0) first_done = c;
            if (c <= 4 || c == 26) begin
                vec++;
                if (en_state8 !== 1'b0) begin errs++; $display("FAIL pb8_idle_en c%0d got %b want 0", c, en_state8); end
            end
            if (c == 5) begin
                vec++;
                if ({en_state8, sel_state_init8} !== 2'b11) begin errs++; $display("FAIL pb8_init_start got %b want 11", {en_state8, sel_state_init8}); end
            end
            if (c >= 18 && c <= 25) begin
                vec++;
                if ({en_state8, rnd_idx8} !== {1'b1, 4'(c - 14)}) begin errs++; $display("FAIL pb8_ad_round c%0d got %b want 1_%0d", c, {en_state8, rnd_idx8}, c - 14); end
            end
            if (c >= 27 && c <= 34) begin
                vec++;
                if ({en_state8, rnd_idx8} !== {1'b1, 4'(c - 23)}) begin errs++; $display("FAIL pb8_dt_round c%0d got %b want 1_%0d", c, {en_state8, rnd_idx8}, c - 23); end
            end
        end
        vec++;
        if (first_done != 49) begin errs++; $display("FAIL pb8_done_cycle got %0d want 49", first_done); end
        delay_i = 16'd0;
    endtask

    task automatic test_stall;
        int first_done;
        first_done = -1;
        next_cycle;
        decrypt_i = 1'b0; ad_blk_no_i = 7'd0; dt_blk_no_i = 8'd2; delay_i = 16'd0; start_i = 1'b1;
        for (int c = 1; c <= 41; c++) begin
            next_cycle;
            start_i = 1'b0;
            dout_full_i = (c >= 14 && c <= 18);
            @(negedge clk);
            if (done_o === 1'b1 && first_done < 0) first_done = c;
            if (c >= 14 && c <= 19) begin
                vec++;
                if ({en_state_o, din_pop_o, dout_push_o, rnd_idx_o} !== 7'd0) begin
                    errs++; $display("FAIL stall_quiet c%0d got %b want 0000000", c, {en_state_o, din_pop_o, dout_push_o, rnd_idx_o});
                end
            end
            if (c == 20) begin
                vec++;
                if ({en_state_o, din_pop_o, dout_push_o} !== 3'b111) begin errs++; $display("FAIL stall_resume got %b want 111", {en_state_o, din_pop_o, dout_push_o}); end
            end
        end
        vec++;
        if (first_done != 40) begin errs++; $display("FAIL stall_done_cycle got %0d want 40", first_done); end
    endtask

    task automatic test_abort;
        int n_din, first_done;
        n_din = 0; first_done = -1;
        next_cycle;
        decrypt_i = 1'b0; ad_blk_no_i = 7'd0; dt_blk_no_i = 8'd2; delay_i = 16'd0; start_i = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            next_cycle;
            start_i = 1'b0;
            abort_i = (c == 17);
            if (c == 18) begin
                decrypt_i = 1'b1; dt_blk_no_i = 8'd1; tag_eq_i = 1'b1; start_i = 1'b1;
            end
            @(negedge clk);
            if (c == 16) begin
                vec++;
                if (en_state_o !== 1'b1) begin errs++; $display("FAIL abort_pre got %b want 1", en_state_o); end
            end
            if (c == 17) begin
                vec++;
                if ({en_state_o, din_pop_o, dout_push_o, sel_xor_ext_o, ad_pop_o} !== 5'b0) begin
                    errs++; $display("FAIL abort_silent got %b want 00000", {en_state_o, din_pop_o, dout_push_o, sel_xor_ext_o, ad_pop_o});
                end
            end
            if (c == 18) begin
                vec++;
                if ({ready_o, done_o, auth_ok_o, auth_fail_o} !== 4'b1000) begin errs++; $display("FAIL abort_idle got %b want 1000", {ready_o, done_o, auth_ok_o, auth_fail_o}); end
            end
        end
        for (int c = 19; c <= 47; c++) begin
            next_cycle;
            start_i = 1'b0;
            @(negedge clk);
            if (din_pop_o) n_din++;
            if (done_o === 1'b1 && first_done < 0) first_done = c;
            if (c == 20) begin
                vec++;
                if ({en_state_o, sel_state_init_o} !== 2'b11) begin errs++; $display("FAIL abort_restart_init got %b want 11", {en_state_o, sel_state_init_o}); end
            end
            if (c == 46) begin
                vec++;
                if ({done_o, auth_ok_o, auth_fail_o, tag_valid_o} !== 4'b1100) begin errs++; $display("FAIL abort_restart_done got %b want 1100", {done_o, auth_ok_o, auth_fail_o, tag_valid_o}); end
            end
        end
        vec++;
        if (n_din != 1 || first_done != 46) begin errs++; $display("FAIL abort_restart_run got pops=%0d done=c%0d want 1 c46", n_din, first_done); end
    endtask

    initial begin
        test_reset;
        test_encrypt;
        test_no_ad;
        test_decrypt;
        test_pb8;
        test_stall;
        test_abort;
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
